cas_player: RTL and testbench



---
 rtl/cas_player.sv | 244 ++++++++++++++++++++++++
 tb/tb_cas_player.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_player.sv
// cas_player: MSX cassette FSK transmitter.
// Takes bytes (with an optional header request) through a one-entry
// holding register and plays them as the 1200/2400 Hz tape waveform the
// BIOS tape routines expect.
// Optional: define CAS_SILENCE_EN to precede long headers with a
// GAP_CYCLES-tick stretch of silence.
module cas_player #(
    parameter int unsigned HALF_2400  = 746,
    parameter int unsigned HALF_1200  = 1492,
    parameter int unsigned LONG_HDR   = 16000,
    parameter int unsigned SHORT_HDR  = 4000,
    parameter int unsigned GAP_CYCLES = 3579545
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ce_3m58_i,
    input  logic       motor_i,
    input  logic [7:0] data_i,
    input  logic [1:0] hdr_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       cas_audio_o,
    output logic       busy_o
);

`ifdef CAS_SILENCE_EN
    typedef enum logic [2:0] {IDLE, GAP, HDR, START, DATA, STOP} state_t;
    localparam logic [21:0] GAP_LAST = 22'(GAP_CYCLES - 1);
`else
    typedef enum logic [2:0] {IDLE, HDR, START, DATA, STOP} state_t;
`endif

    localparam logic [10:0] H_LAST     = 11'(HALF_2400 - 1);
    localparam logic [10:0] F_LAST     = 11'(HALF_1200 - 1);
    localparam logic [13:0] LONG_LAST  = 14'(LONG_HDR - 1);
    localparam logic [13:0] SHORT_LAST = 14'(SHORT_HDR - 1);

    state_t      state;
    state_t      nxt_state;
    state_t      entry_state;

    logic        hold_full;
    logic [7:0]  hold_data;
    logic [1:0]  hold_hdr;

    logic [7:0]  shreg;
    logic        hdr_long;
    logic        fresh;
    logic        level;
    logic [10:0] half_cnt;
    logic [1:0]  hidx;
    logic [2:0]  bidx;
    logic [13:0] hdr_cnt;
`ifdef CAS_SILENCE_EN
    logic [21:0] gap_cnt;
`endif

    logic        tick;
    logic        load;
    logic        take;
    logic        cur_one;
    logic        bit_end;
    logic        hdr_last;
    logic        frame_end;
    logic        seg_end;
    logic        nxt_one;
    logic [2:0]  nxt_bidx;

    assign tick        = ce_3m58_i & motor_i;
    assign load        = valid_i & ~hold_full;
    assign ready_o     = ~hold_full;
    assign busy_o      = (state != IDLE) | hold_full;
    assign cas_audio_o = level & motor_i;

    // First state of a frame, chosen from the header request in the holding register
    always_comb begin
        entry_state = START;
        if (hold_hdr != 2'b00) begin
`ifdef CAS_SILENCE_EN
            entry_state = hold_hdr[1] ? GAP : HDR;
`else
            entry_state = HDR;
`endif
        end
    end

    // Symbol bookkeeping: what the current bit is, whether it ends now, and what follows
    always_comb begin
        cur_one   = 1'b1;
        nxt_state = state;
        nxt_one   = 1'b1;
        nxt_bidx  = '0;
        frame_end = 1'b0;
        hdr_last  = (hdr_cnt == (hdr_long ? LONG_LAST : SHORT_LAST));

        case (state)
            START:   cur_one = 1'b0;
            DATA:    cur_one = shreg[bidx];
            default: cur_one = 1'b1;
        endcase

        // A header cycle and a "0" bit are two halves; a "1" bit is four.
        bit_end = (cur_one && state != HDR) ? (hidx == 2'd3) : (hidx == 2'd1);

        case (state)
            HDR: begin
                if (hdr_last) begin
                    nxt_state = START;
                    nxt_one   = 1'b0;
                end else begin
                    nxt_state = HDR;
                end
            end
            START: begin
                nxt_state = DATA;
                nxt_one   = shreg[0];
            end
            DATA: begin
                if (bidx == 3'd7) begin
                    nxt_state = STOP;
                end else begin
                    nxt_state = DATA;
                    nxt_bidx  = bidx + 3'd1;
                    nxt_one   = shreg[bidx + 3'd1];
                end
            end
            STOP: begin
                if (bidx == 3'd1) begin
                    frame_end = 1'b1;
                    if (hold_full) begin
                        nxt_state = entry_state;
                        nxt_one   = (hold_hdr != 2'b00);
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_state = STOP;
                    nxt_bidx  = 3'd1;
                end
            end
            default: ;
        endcase

        seg_end = tick && !fresh && (half_cnt == '0) && bit_end &&
                  (state inside {HDR, START, DATA, STOP});
    end

    assign take = hold_full & ((state == IDLE) | (seg_end & frame_end));

    // Holding register plus serializer; all timing advances only on ce ticks with the motor running
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_hdr  <= '0;
            shreg     <= '0;
            hdr_long  <= 1'b0;
            fresh     <= 1'b0;
            level     <= 1'b0;
            half_cnt  <= '0;
            hidx      <= '0;
            bidx      <= '0;
            hdr_cnt   <= '0;
`ifdef CAS_SILENCE_EN
            gap_cnt   <= '0;
`endif
        end else begin
            if (load) begin
                hold_data <= data_i;
                hold_hdr  <= hdr_i;
            end
            hold_full <= load | (hold_full & ~take);

            if (state == IDLE) begin
                // The first tick after this take produces the first high sample.
                if (take) begin
                    state    <= entry_state;
                    shreg    <= hold_data;
                    hdr_long <= hold_hdr[1];
                    fresh    <= 1'b1;
                    hidx     <= '0;
                    bidx     <= '0;
                    hdr_cnt  <= '0;
                    half_cnt <= '0;
                    level    <= 1'b0;
`ifdef CAS_SILENCE_EN
                    gap_cnt  <= '0;
`endif
                end
            end
`ifdef CAS_SILENCE_EN
            else if (tick && state == GAP) begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt <= '0;
                    state   <= HDR;
                    fresh   <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 22'd1;
                end
            end
`endif
            else if (tick) begin
                if (fresh) begin
                    fresh    <= 1'b0;
                    level    <= 1'b1;
                    hidx     <= '0;
                    half_cnt <= (state == HDR) ? H_LAST : F_LAST;
                end else if (half_cnt != '0) begin
                    half_cnt <= half_cnt - 11'd1;
                end else if (!bit_end) begin
                    // Even half indices are high, odd ones low.
                    hidx     <= hidx + 2'd1;
                    level    <= hidx[0];
                    half_cnt <= cur_one ? H_LAST : F_LAST;
                end else begin
                    // Bit boundary; a frame end here hands over to the next entry on the same tick.
                    state   <= nxt_state;
                    hidx    <= '0;
                    bidx    <= nxt_bidx;
                    hdr_cnt <= (state == HDR && nxt_state == HDR) ? hdr_cnt + 14'd1 : '0;
                    if (take) begin
                        shreg    <= hold_data;
                        hdr_long <= hold_hdr[1];
                    end
                    if (nxt_state == IDLE) begin
                        level <= 1'b0;
                    end
`ifdef CAS_SILENCE_EN
                    else if (nxt_state == GAP) begin
                        level   <= 1'b0;
                        gap_cnt <= 22'd1;
                    end
`endif
                    else begin
                        level    <= 1'b1;
                        half_cnt <= nxt_one ? H_LAST : F_LAST;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// Scoreboard bench for cas_player: each issued byte expands into its list
// of expected half-periods (level, length in ticks); a monitor measures the
// waveform between edges and checks it against that list.
module tb_cas_player;

    localparam int H  = 5;
    localparam int F  = 10;
    localparam int LH = 12;
    localparam int SH = 5;
    localparam int G  = 50;
    localparam int BYTE_TICKS = 11 * 4 * H;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce      = 1'b0;
    logic       motor   = 1'b1;
    logic       valid   = 1'b0;
    logic [7:0] data    = '0;
    logic [1:0] hdr     = '0;
    logic       ready;
    logic       audio;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int tc = 0;
    int ce_mode = 0;
    bit rand_motor = 1'b0;
    bit motor_req  = 1'b1;

    cas_player #(
        .HALF_2400 (H),
        .HALF_1200 (F),
        .LONG_HDR  (LH),
        .SHORT_HDR (SH),
        .GAP_CYCLES(G)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .ce_3m58_i  (ce),
        .motor_i    (motor),
        .data_i     (data),
        .hdr_i      (hdr),
        .valid_i    (valid),
        .ready_o    (ready),
        .cas_audio_o(audio),
        .busy_o     (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: frame = optional header cycles, start "0", 8 data bits LSB first, two "1" stop bits
    task automatic push_half(input int lvl, input int len);
        exp_q.push_back(len * 2 + lvl);
    endtask

    task automatic push_bit(input bit b);
        if (b) begin
            push_half(1, H); push_half(0, H); push_half(1, H); push_half(0, H);
        end else begin
            push_half(1, F); push_half(0, F);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [1:0] h);
        int n;
        if (h != 2'b00) begin
            n = (h == 2'b01) ? SH : LH;
            for (int i = 0; i < n; i++) begin
                push_half(1, H);
                push_half(0, H);
            end
        end
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(d[i]);
        push_bit(1'b1);
        push_bit(1'b1);
    endtask

    // Tick clock of the bench: ce pulses that arrive while the motor runs
    initial forever begin
        @(posedge clk);
        if (ce && motor) tc <= tc + 1;
    end

    // ce generator: every third clock, or random
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ce_mode == 0) begin
                ce = (k == 2);
                k  = (k == 2) ? 0 : k + 1;
            end else begin
                ce = ($urandom_range(0, 2) == 0);
            end
        end
    end

    // Motor driver: follows motor_req, or wanders randomly
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_motor) begin
            if (motor) begin
                if ($urandom_range(0, 149) == 0) motor = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                motor = 1'b1;
            end
        end else begin
            motor = motor_req;
        end
    end

    // Monitor: every edge (or busy falling) closes one half-period
    initial begin
        bit have_prev = 1'b0;
        logic prev_lvl = 1'b0;
        logic prev_busy = 1'b0;
        int last_tc = 0;
        int e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                have_prev = 1'b0;
                prev_lvl  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (motor) begin
                    if (audio !== prev_lvl) begin
                        if (have_prev) begin
                            if (exp_q.size() == 0) begin
                                compared++;
                                mismatched++;
                                $display("FAIL half_unexpected: got level %0d after %0d ticks, want nothing", prev_lvl, tc - last_tc);
                            end else begin
                                e = exp_q.pop_front();
                                check("half_level", int'(prev_lvl), e % 2);
                                check("half_len", tc - last_tc, e / 2);
                            end
                        end else begin
                            check("first_edge_level", int'(audio), 1);
                        end
                        have_prev = 1'b1;
                        last_tc   = tc;
                        prev_lvl  = audio;
                    end
                end else begin
                    check("motor_off_audio", int'(audio), 0);
                end
                if (prev_busy && !busy) begin
                    if (have_prev) begin
                        if (exp_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL tail_unexpected: got level %0d after %0d ticks, want nothing", prev_lvl, tc - last_tc);
                        end else begin
                            e = exp_q.pop_front();
                            check("tail_level", int'(prev_lvl), e % 2);
                            check("tail_len", tc - last_tc, e / 2);
                        end
                    end
                    have_prev = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] h);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", int'(ready), 1);
        push_frame(d, h);
        data  = d;
        hdr   = h;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_rise(output int t);
        int n = 0;
        while (!audio && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("rise_wait", int'(audio), 1);
        t = tc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", int'(busy), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    // Send from idle and check the handshake and the position of the first high sample
    task automatic send_idle_checked(input logic [7:0] d, input logic [1:0] h, input int delay);
        int t0;
        int t1;
        send(d, h);
        check("ready_after_load", int'(ready), 0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_take", int'(ready), 1);
        check("busy_after_take", int'(busy), 1);
        t0 = tc;
        wait_rise(t1);
        check("first_rise_delay", t1 - t0, delay);
    endtask

    initial begin
        int t1;
        int t2;
        int n;
        logic [7:0] rd;
        logic [1:0] rh;

        repeat (3) @(negedge clk);
        check("reset_audio", int'(audio), 0);
        check("reset_ready", int'(ready), 1);
        check("reset_busy", int'(busy), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x00 without header: frame length from first high sample to busy falling
        send_idle_checked(8'h00, 2'b00, 1);
        t1 = tc;
        n  = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_wait", int'(busy), 0);
        t2 = tc;
        check("frame_ticks", t2 - t1, BYTE_TICKS);
        wait_idle();

        send(8'hFF, 2'b00);
        wait_idle();
        send_idle_checked(8'hA5, 2'b01, 1);
        wait_idle();

        // Back-to-back stream: the second entry waits in the holding register
        send(8'h1F, 2'b00);
        send(8'h2E, 2'b00);
        check("ready_while_queued", int'(ready), 0);
        wait_idle();

        // Motor drop in the middle of data bit 3
        send(8'h5A, 2'b00);
        wait_rise(t1);
        n = 0;
        while (tc < t1 + 16 * H + 7 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        motor_req = 1'b0;
        repeat (60) @(negedge clk);
        motor_req = 1'b1;
        wait_idle();

        // Byte arriving in idle with the motor stopped is taken but not played
        motor_req = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h3C, 2'b00);
        repeat (3) @(negedge clk);
        check("motor_off_taken_ready", int'(ready), 1);
        check("motor_off_taken_busy", int'(busy), 1);
        repeat (50) @(negedge clk);
        check("motor_off_idle_audio", int'(audio), 0);
        motor_req = 1'b1;
        wait_idle();

        // Random bytes, random ce spacing and random motor pauses
        ce_mode    = 1;
        rand_motor = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            rh = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
            send(rd, rh);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 300)) @(negedge clk);
        end
        rand_motor = 1'b0;
        wait_idle();
        ce_mode = 0;

        // Reset in the middle of a long header, then a fresh long header
        send(8'h77, 2'b10);
        repeat (150) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_audio", int'(audio), 0);
        check("midreset_ready", int'(ready), 1);
        check("midreset_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
`ifdef CAS_SILENCE_EN
        send_idle_checked(8'h81, 2'b10, G + 1);
`else
        send_idle_checked(8'h81, 2'b10, 1);
`endif
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
